// File: rtl/gtx_reset_seq.sv
// rtl/gtx_reset_seq.sv - GTXE2 per-channel TX/RX sub-reset sequencer in the gtrefclk domain.
// Independent TX and RX FSMs; every output is a flop loaded from the next-state decode.
module gtx_reset_seq #(
  parameter int TXPMARESET_TIME     = 1,
  parameter int RXPMARESET_TIME     = 17,
  parameter int RXCDRPHRESET_TIME   = 1,
  parameter int RXCDRFREQRESET_TIME = 1,
  parameter int RXDFELPMRESET_TIME  = 15,
  parameter int RXISCANRESET_TIME   = 1,
  parameter int PCSRESET_TIME       = 4
) (
  input  logic       gtrefclk,
  input  logic       extrst,
  input  logic       cplllock,
  input  logic       txreset,
  input  logic       rxreset,
  input  logic       txuserrdy,
  input  logic       rxuserrdy,
  output logic       txpmareset,
  output logic       txpcsreset,
  output logic       rxpmareset,
  output logic       rxcdrphreset,
  output logic       rxcdrfreqreset,
  output logic       rxdfelpmreset,
  output logic       rxiscanreset,
  output logic       rxpcsreset,
  output logic       txresetdone,
  output logic       rxresetdone,
  output logic [1:0] tx_state,
  output logic [2:0] rx_state
);

  typedef enum logic [1:0] {TX_PMA, TX_WAIT, TX_PCS, TX_DONE} tx_state_t;
  typedef enum logic [2:0] {
    RX_PMA, RX_CDRPH, RX_CDRFREQ, RX_DFE, RX_ISCAN, RX_WAIT, RX_PCS, RX_DONE
  } rx_state_t;

  // The PMA states compare against the full time because the release edge itself loads
  // count 1; states entered from another state start at 0 and so exit at TIME-1.
  localparam logic [6:0] TX_PMA_LAST   = 7'(TXPMARESET_TIME);
  localparam logic [6:0] RX_PMA_LAST   = 7'(RXPMARESET_TIME);
  localparam logic [6:0] CDRPH_LAST    = 7'(RXCDRPHRESET_TIME - 1);
  localparam logic [6:0] CDRFREQ_LAST  = 7'(RXCDRFREQRESET_TIME - 1);
  localparam logic [6:0] DFE_LAST      = 7'(RXDFELPMRESET_TIME - 1);
  localparam logic [6:0] ISCAN_LAST    = 7'(RXISCANRESET_TIME - 1);
  localparam logic [6:0] PCS_LAST      = 7'(PCSRESET_TIME - 1);

  tx_state_t tx_q, tx_next;
  rx_state_t rx_q, rx_next;
  logic [6:0] tx_cnt, tx_cnt_next;
  logic [6:0] rx_cnt, rx_cnt_next;
  logic [6:0] rx_last;
  logic       txrdy_s1, txrdy_s2, rxrdy_s1, rxrdy_s2;

  always_ff @(posedge gtrefclk or posedge extrst) begin
    if (extrst) begin
      txrdy_s1 <= 1'b0;
      txrdy_s2 <= 1'b0;
      rxrdy_s1 <= 1'b0;
      rxrdy_s2 <= 1'b0;
    end else begin
      txrdy_s1 <= txuserrdy;
      txrdy_s2 <= txrdy_s1;
      rxrdy_s1 <= rxuserrdy;
      rxrdy_s2 <= rxrdy_s1;
    end
  end

  always_comb begin
    tx_next     = tx_q;
    tx_cnt_next = tx_cnt + 7'd1;
    if (txreset || !cplllock) begin
      tx_next     = TX_PMA;
      tx_cnt_next = 7'd0;
    end else begin
      case (tx_q)
        TX_PMA: if (tx_cnt == TX_PMA_LAST) begin
          tx_next     = TX_WAIT;
          tx_cnt_next = 7'd0;
        end
        TX_WAIT: begin
          tx_cnt_next = 7'd0;
          if (txrdy_s2) tx_next = TX_PCS;
        end
        TX_PCS: if (tx_cnt == PCS_LAST) begin
          tx_next     = TX_DONE;
          tx_cnt_next = 7'd0;
        end
        default: tx_cnt_next = 7'd0;
      endcase
    end
  end

  always_comb begin
    rx_last = 7'd0;
    case (rx_q)
      RX_PMA:     rx_last = RX_PMA_LAST;
      RX_CDRPH:   rx_last = CDRPH_LAST;
      RX_CDRFREQ: rx_last = CDRFREQ_LAST;
      RX_DFE:     rx_last = DFE_LAST;
      RX_ISCAN:   rx_last = ISCAN_LAST;
      RX_PCS:     rx_last = PCS_LAST;
      default:    rx_last = 7'd0;
    endcase
  end

  always_comb begin
    rx_next     = rx_q;
    rx_cnt_next = rx_cnt + 7'd1;
    if (rxreset || !cplllock) begin
      rx_next     = RX_PMA;
      rx_cnt_next = 7'd0;
    end else begin
      case (rx_q)
        RX_WAIT: begin
          rx_cnt_next = 7'd0;
          if (rxrdy_s2) rx_next = RX_PCS;
        end
        RX_DONE: rx_cnt_next = 7'd0;
        default: if (rx_cnt == rx_last) begin
          rx_next     = rx_state_t'(rx_q + 3'd1);
          rx_cnt_next = 7'd0;
        end
      endcase
    end
  end

  always_ff @(posedge gtrefclk or posedge extrst) begin
    if (extrst) begin
      tx_q           <= TX_PMA;
      rx_q           <= RX_PMA;
      tx_cnt         <= 7'd0;
      rx_cnt         <= 7'd0;
      txpmareset     <= 1'b1;
      txpcsreset     <= 1'b0;
      txresetdone    <= 1'b0;
      rxpmareset     <= 1'b1;
      rxcdrphreset   <= 1'b0;
      rxcdrfreqreset <= 1'b0;
      rxdfelpmreset  <= 1'b0;
      rxiscanreset   <= 1'b0;
      rxpcsreset     <= 1'b0;
      rxresetdone    <= 1'b0;
    end else begin
      tx_q           <= tx_next;
      rx_q           <= rx_next;
      tx_cnt         <= tx_cnt_next;
      rx_cnt         <= rx_cnt_next;
      txpmareset     <= (tx_next == TX_PMA);
      txpcsreset     <= (tx_next == TX_PCS);
      txresetdone    <= (tx_next == TX_DONE);
      rxpmareset     <= (rx_next == RX_PMA);
      rxcdrphreset   <= (rx_next == RX_CDRPH);
      rxcdrfreqreset <= (rx_next == RX_CDRFREQ);
      rxdfelpmreset  <= (rx_next == RX_DFE);
      rxiscanreset   <= (rx_next == RX_ISCAN);
      rxpcsreset     <= (rx_next == RX_PCS);
      rxresetdone    <= (rx_next == RX_DONE);
    end
  end

  assign tx_state = tx_q;
  assign rx_state = rx_q;

endmodule
